// File: rtl/pipeline_mul.sv
// ---------------------------------------------------------------------------
// pipeline_mul
//   Fully pipelined signed (two's complement) DATA_W x DATA_W multiplier for
//   the mini_core_accel datapath. It accepts one operand pair per clock and
//   returns each product in order, DATA_W clocks after acceptance.
//
//   The structure is shift-and-add. Each stage adds one partial product, and
//   no multiplier primitive is used. A pair captured at edge T fills stage 0
//   at edge T and reaches stage DATA_W-1 at edge T+DATA_W-1. The output
//   register then presents it at edge T+DATA_W.
//
// Ports
//   clk           in   1         single clock, rising edge
//   rst           in   1         synchronous, active-high reset
//   start         in   1         operand-valid; pair sampled on each edge with start=1
//   multiplier    in   DATA_W    signed operand A
//   multiplicand  in   DATA_W    signed operand B
//   ready         out  1         result-valid pulse, one per accepted pair
//   result        out  2*DATA_W  signed product A*B; holds last product when ready=0
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pipeline_mul_stage
//   One shift-and-add step. The stage adds B*A[IDX] << IDX to the incoming
//   accumulator and registers the sum with its own copies of A, B and valid.
//   Stage DATA_W-1 subtracts instead of adding, because the A sign bit
//   weighs -2^(DATA_W-1).
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   vld_in     token valid entering this stage
//   a_in/b_in  operand copies entering this stage
//   acc_in     partial sum entering this stage
//   vld_out, a_out, b_out, acc_out   registered copies for the next stage
// ---------------------------------------------------------------------------
module pipeline_mul_stage #(
   parameter int DATA_W = 8,
   parameter int IDX    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_in,
   input  logic [DATA_W-1:0]     a_in,
   input  logic [DATA_W-1:0]     b_in,
   input  logic [2*DATA_W-1:0]   acc_in,
   output logic                  vld_out,
   output logic [DATA_W-1:0]     a_out,
   output logic [DATA_W-1:0]     b_out,
   output logic [2*DATA_W-1:0]   acc_out
);

   localparam int PW = 2*DATA_W;

   logic [PW-1:0] b_ext;
   logic [PW-1:0] pp;
   logic [PW-1:0] acc_nxt;

   always_comb begin
      b_ext = {{DATA_W{b_in[DATA_W-1]}}, b_in};
      pp    = a_in[IDX] ? (b_ext << IDX) : '0;
      // Two's complement: the MSB of A carries negative weight.
      if (IDX == DATA_W-1) acc_nxt = acc_in - pp;
      else                 acc_nxt = acc_in + pp;
   end

   // rst also masks the incoming token, so start is ignored on reset edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_out <= 1'b0;
         a_out   <= '0;
         b_out   <= '0;
         acc_out <= '0;
      end else begin
         vld_out <= vld_in;
         a_out   <= a_in;
         b_out   <= b_in;
         acc_out <= acc_nxt;
      end
   end

endmodule

module pipeline_mul #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     multiplier,
   input  logic [DATA_W-1:0]     multiplicand,
   output logic                  ready,
   output logic [2*DATA_W-1:0]   result
);

   // Index k holds the signals entering stage k. Index DATA_W is the output
   // of the last stage.
   logic [DATA_W:0]                 vld_pipe;
   logic [DATA_W:0][DATA_W-1:0]     a_pipe;
   logic [DATA_W:0][DATA_W-1:0]     b_pipe;
   logic [DATA_W:0][2*DATA_W-1:0]   acc_pipe;

   assign vld_pipe[0] = start;
   assign a_pipe[0]   = multiplier;
   assign b_pipe[0]   = multiplicand;
   assign acc_pipe[0] = '0;

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_stage
      pipeline_mul_stage #(
         .DATA_W (DATA_W),
         .IDX    (gi)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .vld_in  (vld_pipe[gi]),
         .a_in    (a_pipe[gi]),
         .b_in    (b_pipe[gi]),
         .acc_in  (acc_pipe[gi]),
         .vld_out (vld_pipe[gi+1]),
         .a_out   (a_pipe[gi+1]),
         .b_out   (b_pipe[gi+1]),
         .acc_out (acc_pipe[gi+1])
      );
   end

   // The operand copies that leave the last stage are never needed.
   logic unused_operands;
   assign unused_operands = ^{a_pipe[DATA_W], b_pipe[DATA_W]};

   // Output register. result only moves on a valid token, so bubbles hold
   // the last product.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready  <= 1'b0;
         result <= '0;
      end else begin
         ready <= vld_pipe[DATA_W];
         if (vld_pipe[DATA_W]) result <= acc_pipe[DATA_W];
      end
   end

endmodule

// File: tb/tb_pipeline_mul.sv
module tb_pipeline_mul;

   localparam int DATA_W = 8;
   localparam int LAT    = DATA_W;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  multiplier;
   logic [7:0]  multiplicand;
   logic        ready;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        v;
      logic [15:0] r;
      string       tag;
   } exp_t;

   exp_t        q[$];
   logic [15:0] last_res;

   always #5 clk = ~clk;

   pipeline_mul #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplier   (multiplier),
      .multiplicand (multiplicand),
      .ready        (ready),
      .result       (result)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock slot. Queue the hand-computed expectation for this slot, then
   // check the slot issued LAT edges earlier.
   task automatic cyc(input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] er, input string tag);
      exp_t e, f;
      start        = s;
      multiplier   = a;
      multiplicand = b;
      @(posedge clk); #1;
      e.v = s; e.r = er; e.tag = tag;
      q.push_back(e);
      if (q.size() > LAT) begin
         f = q.pop_front();
         chk({f.tag, "_rdy"}, {15'b0, ready}, {15'b0, f.v});
         if (f.v) last_res = f.r;
         chk({f.tag, "_res"}, result, last_res);
      end
   endtask

   // Hold rst for n edges with start high and junk operands. Nothing may
   // come out.
   task automatic do_reset(input int n, input string tag);
      exp_t e;
      rst   = 1'b1;
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
         multiplier   = 8'($urandom);
         multiplicand = 8'($urandom);
         @(posedge clk); #1;
         chk({tag, "_rdy"}, {15'b0, ready}, 16'h0000);
         chk({tag, "_res"}, result, 16'h0000);
      end
      rst      = 1'b0;
      start    = 1'b0;
      last_res = 16'h0000;
      q.delete();
      e.v = 1'b0; e.r = 16'h0000; e.tag = {tag, "_drain"};
      for (int i = 0; i < LAT; i++) q.push_back(e);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; multiplier = '0; multiplicand = '0;
      last_res = 16'h0000;

      // Reset, then an idle pipeline.
      do_reset(2, "reset");
      for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 8'h00, 16'h0000, "idle");

      // Streaming, back-to-back.
      cyc(1'b1, 8'(4),    8'(3),    16'h000C, "s_4x3");
      cyc(1'b1, 8'(-4),   8'(3),    16'hFFF4, "s_m4x3");
      cyc(1'b1, 8'(18),   8'(9),    16'h00A2, "s_18x9");
      cyc(1'b1, 8'(5),    8'(6),    16'h001E, "s_5x6");
      cyc(1'b1, 8'(123),  8'(-6),   16'hFD1E, "s_123xm6");
      cyc(1'b1, 8'(-4),   8'(-5),   16'h0014, "s_m4xm5");
      // Zeros and signs.
      cyc(1'b1, 8'(-21),  8'(0),    16'h0000, "z_m21x0");
      cyc(1'b1, 8'(0),    8'(3),    16'h0000, "z_0x3");
      cyc(1'b1, 8'(64),   8'(-2),   16'hFF80, "z_64xm2");
      cyc(1'b1, 8'(-64),  8'(2),    16'hFF80, "z_m64x2");
      cyc(1'b1, 8'(12),   8'(-12),  16'hFF70, "z_12xm12");
      // Corners.
      cyc(1'b1, 8'(-128), 8'(1),    16'hFF80, "c_m128x1");
      cyc(1'b1, 8'(-128), 8'(-128), 16'h4000, "c_m128xm128");
      cyc(1'b1, 8'(127),  8'(127),  16'h3F01, "c_127x127");
      // Bubble between two pairs.
      cyc(1'b1, 8'(2),    8'(3),    16'h0006, "b_2x3");
      cyc(1'b0, 8'(55),   8'(77),   16'h0000, "b_bubble");
      cyc(1'b1, 8'(7),    8'(7),    16'h0031, "b_7x7");
      for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 8'h00, 8'h00, 16'h0000, "flush");

      // Reset mid-stream. The four in-flight pairs must never appear.
      cyc(1'b1, 8'(10),   8'(10),   16'h0064, "m_10x10");
      cyc(1'b1, 8'(-7),   8'(9),    16'hFFC1, "m_m7x9");
      cyc(1'b1, 8'(33),   8'(2),    16'h0042, "m_33x2");
      cyc(1'b1, 8'(1),    8'(1),    16'h0001, "m_1x1");
      do_reset(1, "midrst");
      cyc(1'b1, 8'(-3),   8'(5),    16'hFFF1, "p_m3x5");
      for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 8'h00, 8'h00, 16'h0000, "tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
